// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-requester round-robin arbiter onto a single-port memory,
//               with optional grant locking (macro MEM_ARB_LOCK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             a_req_i,
    input  logic             a_we_i,
    input  logic [DEPTH-1:0] a_addr_i,
    input  logic [WIDTH-1:0] a_wdata_i,
    input  logic             a_lock_i,
    output logic             a_gnt_o,
    output logic             a_rvalid_o,
    output logic [WIDTH-1:0] a_rdata_o,

    input  logic             b_req_i,
    input  logic             b_we_i,
    input  logic [DEPTH-1:0] b_addr_i,
    input  logic [WIDTH-1:0] b_wdata_i,
    input  logic             b_lock_i,
    output logic             b_gnt_o,
    output logic             b_rvalid_o,
    output logic [WIDTH-1:0] b_rdata_o,

    output logic             mem_wr_en_o,
    output logic [DEPTH-1:0] mem_addr_wr_o,
    output logic [WIDTH-1:0] mem_data_wr_o,
    output logic             mem_rd_en_o,
    output logic [DEPTH-1:0] mem_addr_rd_o,
    input  logic [WIDTH-1:0] mem_data_rd_i
);

`ifdef MEM_ARB_LOCK_EN
    localparam logic c_LOCK_EN = 1'b1;
`else
    localparam logic c_LOCK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t r_state;
    logic   r_last_b;
    logic   w_gnt_a;
    logic   w_gnt_b;
    logic   w_lock_a;
    logic   w_lock_b;

    // With locking disabled the lock inputs fold to zero and LOCK_x is unreachable.
    assign w_lock_a = c_LOCK_EN & a_lock_i;
    assign w_lock_b = c_LOCK_EN & b_lock_i;

    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (!rst_i) begin
            case (r_state)
                LOCK_A:  w_gnt_a = a_req_i;
                LOCK_B:  w_gnt_b = b_req_i;
                default: begin
                    if (a_req_i && b_req_i) begin
                        w_gnt_a = r_last_b;
                        w_gnt_b = !r_last_b;
                    end else begin
                        w_gnt_a = a_req_i;
                        w_gnt_b = b_req_i;
                    end
                end
            endcase
        end
    end

    assign a_gnt_o = w_gnt_a;
    assign b_gnt_o = w_gnt_b;

    always_comb begin
        mem_wr_en_o   = 1'b0;
        mem_rd_en_o   = 1'b0;
        mem_addr_wr_o = '0;
        mem_addr_rd_o = '0;
        mem_data_wr_o = '0;
        if (w_gnt_a) begin
            mem_wr_en_o   = a_we_i;
            mem_rd_en_o   = !a_we_i;
            mem_addr_wr_o = a_addr_i;
            mem_addr_rd_o = a_addr_i;
            mem_data_wr_o = a_wdata_i;
        end else if (w_gnt_b) begin
            mem_wr_en_o   = b_we_i;
            mem_rd_en_o   = !b_we_i;
            mem_addr_wr_o = b_addr_i;
            mem_addr_rd_o = b_addr_i;
            mem_data_wr_o = b_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_last_b   <= 1'b1;
            a_rvalid_o <= 1'b0;
            b_rvalid_o <= 1'b0;
            a_rdata_o  <= '0;
            b_rdata_o  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_a && w_lock_a)
                        r_state <= LOCK_A;
                    else if (w_gnt_b && w_lock_b)
                        r_state <= LOCK_B;
                end
                LOCK_A:  if (!w_lock_a) r_state <= IDLE;
                LOCK_B:  if (!w_lock_b) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            if (w_gnt_a || w_gnt_b)
                r_last_b <= w_gnt_b;

            // Memory read data is combinational, so it is captured at the grant edge.
            a_rvalid_o <= w_gnt_a && !a_we_i;
            b_rvalid_o <= w_gnt_b && !b_we_i;
            if (w_gnt_a && !a_we_i)
                a_rdata_o <= mem_data_rd_i;
            if (w_gnt_b && !b_we_i)
                b_rdata_o <= mem_data_rd_i;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        a_req_i, a_we_i, a_lock_i;
    logic [3:0]  a_addr_i;
    logic [63:0] a_wdata_i;
    logic        b_req_i, b_we_i, b_lock_i;
    logic [3:0]  b_addr_i;
    logic [63:0] b_wdata_i;
    logic        a_gnt_o, a_rvalid_o, b_gnt_o, b_rvalid_o;
    logic [63:0] a_rdata_o, b_rdata_o;
    logic        mem_wr_en_o, mem_rd_en_o;
    logic [3:0]  mem_addr_wr_o, mem_addr_rd_o;
    logic [63:0] mem_data_wr_o;
    logic [63:0] mem_data_rd_i;

    logic [63:0] tb_mem [16] = '{default: '0};

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [63:0] ref_mem [16] = '{default: '0};
    bit          m_last_was_b;
    int          m_owner;          // 0 none, 1 A holds lock, 2 B holds lock
    logic        exp_a_rv, exp_b_rv;
    logic [63:0] exp_a_rd, exp_b_rd;

    mem_port_arbiter #(.WIDTH(64), .DEPTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .a_req_i(a_req_i), .a_we_i(a_we_i), .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i),
        .a_lock_i(a_lock_i), .a_gnt_o(a_gnt_o), .a_rvalid_o(a_rvalid_o), .a_rdata_o(a_rdata_o),
        .b_req_i(b_req_i), .b_we_i(b_we_i), .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i),
        .b_lock_i(b_lock_i), .b_gnt_o(b_gnt_o), .b_rvalid_o(b_rvalid_o), .b_rdata_o(b_rdata_o),
        .mem_wr_en_o(mem_wr_en_o), .mem_addr_wr_o(mem_addr_wr_o), .mem_data_wr_o(mem_data_wr_o),
        .mem_rd_en_o(mem_rd_en_o), .mem_addr_rd_o(mem_addr_rd_o), .mem_data_rd_i(mem_data_rd_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) if (mem_wr_en_o) tb_mem[mem_addr_wr_o] <= mem_data_wr_o;
    assign mem_data_rd_i = tb_mem[mem_addr_rd_o];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last_was_b = 1'b1;
        m_owner      = 0;
        exp_a_rv     = 1'b0;
        exp_b_rv     = 1'b0;
        exp_a_rd     = '0;
        exp_b_rd     = '0;
    endtask

    task automatic set_a(input logic req, input logic we, input logic [3:0] addr,
                         input logic [63:0] wdata, input logic lock);
        a_req_i = req; a_we_i = we; a_addr_i = addr; a_wdata_i = wdata; a_lock_i = lock;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [3:0] addr,
                         input logic [63:0] wdata, input logic lock);
        b_req_i = req; b_we_i = we; b_addr_i = addr; b_wdata_i = wdata; b_lock_i = lock;
    endtask

    // One clock: check grant and memory drive mid-cycle, then read returns after the edge.
    task automatic cycle(output logic ga_obs, output logic gb_obs);
        logic        ega, egb;
        logic        e_wr, e_rd;
        logic [3:0]  e_addr;
        logic [63:0] e_data;
        @(negedge clk_i);
        ega = 1'b0;
        egb = 1'b0;
        if (!rst_i) begin
            if (m_owner == 1)      ega = a_req_i;
            else if (m_owner == 2) egb = b_req_i;
            else if (a_req_i && b_req_i) begin
                if (m_last_was_b) ega = 1'b1; else egb = 1'b1;
            end else begin
                ega = a_req_i;
                egb = b_req_i;
            end
        end
        e_wr = 1'b0; e_rd = 1'b0; e_addr = '0; e_data = '0;
        if (ega) begin
            e_wr = a_we_i; e_rd = !a_we_i; e_addr = a_addr_i; e_data = a_wdata_i;
        end else if (egb) begin
            e_wr = b_we_i; e_rd = !b_we_i; e_addr = b_addr_i; e_data = b_wdata_i;
        end
        ga_obs = a_gnt_o;
        gb_obs = b_gnt_o;
        chk("a_gnt", {63'd0, a_gnt_o}, {63'd0, ega});
        chk("b_gnt", {63'd0, b_gnt_o}, {63'd0, egb});
        chk("mem_wr_en", {63'd0, mem_wr_en_o}, {63'd0, e_wr});
        chk("mem_rd_en", {63'd0, mem_rd_en_o}, {63'd0, e_rd});
        chk("mem_addr_wr", {60'd0, mem_addr_wr_o}, {60'd0, e_addr});
        chk("mem_addr_rd", {60'd0, mem_addr_rd_o}, {60'd0, e_addr});
        chk("mem_data_wr", mem_data_wr_o, e_data);

        @(posedge clk_i);
        if (rst_i) begin
            model_reset();
        end else begin
            exp_a_rv = ega && !a_we_i;
            exp_b_rv = egb && !b_we_i;
            if (exp_a_rv) exp_a_rd = ref_mem[a_addr_i];
            if (exp_b_rv) exp_b_rd = ref_mem[b_addr_i];
            if (ega && a_we_i) ref_mem[a_addr_i] = a_wdata_i;
            if (egb && b_we_i) ref_mem[b_addr_i] = b_wdata_i;
`ifdef MEM_ARB_LOCK_EN
            if (m_owner == 1 && !a_lock_i)      m_owner = 0;
            else if (m_owner == 2 && !b_lock_i) m_owner = 0;
            else if (m_owner == 0 && ega && a_lock_i) m_owner = 1;
            else if (m_owner == 0 && egb && b_lock_i) m_owner = 2;
`endif
            if (ega) m_last_was_b = 1'b0;
            if (egb) m_last_was_b = 1'b1;
        end
        #1;
        chk("a_rvalid", {63'd0, a_rvalid_o}, {63'd0, exp_a_rv});
        chk("b_rvalid", {63'd0, b_rvalid_o}, {63'd0, exp_b_rv});
        chk("a_rdata", a_rdata_o, exp_a_rd);
        chk("b_rdata", b_rdata_o, exp_b_rd);
    endtask

    initial begin
        logic ga, gb;
        bit   pa, pb;
        model_reset();
        rst_i = 1'b1;
        set_a(1'b1, 1'b0, 4'd1, 64'd0, 1'b0);
        set_b(1'b1, 1'b1, 4'd2, 64'h55, 1'b0);

        // Requests under reset must see no grants and no memory enables
        cycle(ga, gb);
        cycle(ga, gb);
        #1 rst_i = 1'b0;

        // A write then read of address 3
        set_b(1'b0, 1'b0, 4'd0, 64'd0, 1'b0);
        set_a(1'b1, 1'b1, 4'd3, 64'h1122334455667788, 1'b0);
        cycle(ga, gb);
        chk("w3_gnt_a", {63'd0, ga}, 64'd1);
        set_a(1'b1, 1'b0, 4'd3, 64'd0, 1'b0);
        cycle(ga, gb);
        chk("r3_rvalid", {63'd0, a_rvalid_o}, 64'd1);
        chk("r3_rdata", a_rdata_o, 64'h1122334455667788);
        set_a(1'b0, 1'b0, 4'd0, 64'd0, 1'b0);
        cycle(ga, gb);
        chk("r3_rvalid_once", {63'd0, a_rvalid_o}, 64'd0);

        // Fresh reset, then both read every cycle: expect A, B, A, B
        #1 rst_i = 1'b1;
        cycle(ga, gb);
        #1 rst_i = 1'b0;
        set_a(1'b1, 1'b0, 4'd3, 64'd0, 1'b0);
        set_b(1'b1, 1'b0, 4'd7, 64'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(ga, gb);
            chk($sformatf("rr_a_%0d", i), {63'd0, ga}, (i % 2 == 0) ? 64'd1 : 64'd0);
            chk($sformatf("rr_b_%0d", i), {63'd0, gb}, (i % 2 == 1) ? 64'd1 : 64'd0);
        end

        // A writes 0xAA to 5 while B reads 5: A first, B sees the new data
        set_a(1'b1, 1'b1, 4'd5, 64'hAA, 1'b0);
        set_b(1'b1, 1'b0, 4'd5, 64'd0, 1'b0);
        cycle(ga, gb);
        chk("wr_rd_gnt_a", {63'd0, ga}, 64'd1);
        set_a(1'b0, 1'b0, 4'd0, 64'd0, 1'b0);
        cycle(ga, gb);
        chk("wr_rd_gnt_b", {63'd0, gb}, 64'd1);
        chk("wr_rd_b_rdata", b_rdata_o, 64'hAA);

        // A access so B wins the next tie, then B holds lock for 3 cycles
        set_b(1'b0, 1'b0, 4'd0, 64'd0, 1'b0);
        set_a(1'b1, 1'b0, 4'd1, 64'd0, 1'b0);
        cycle(ga, gb);
        set_b(1'b1, 1'b0, 4'd5, 64'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(ga, gb);
`ifdef MEM_ARB_LOCK_EN
            chk($sformatf("lock_a_stall_%0d", i), {63'd0, ga}, 64'd0);
`endif
        end
        b_lock_i = 1'b0;
        cycle(ga, gb);
        cycle(ga, gb);
`ifdef MEM_ARB_LOCK_EN
        chk("lock_release_a", {63'd0, ga}, 64'd1);
`endif

        // Lock input held on A with both requesting
        set_a(1'b1, 1'b0, 4'd2, 64'd0, 1'b1);
        set_b(1'b1, 1'b0, 4'd6, 64'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(ga, gb);
`ifndef MEM_ARB_LOCK_EN
            chk($sformatf("nolock_alt_%0d", i), {63'd0, ga ^ gb}, 64'd1);
`endif
        end
        set_a(1'b0, 1'b0, 4'd0, 64'd0, 1'b0);
        set_b(1'b0, 1'b0, 4'd0, 64'd0, 1'b0);
        cycle(ga, gb);

        // Reset lands in the cycle after a read grant
        set_a(1'b1, 1'b0, 4'd5, 64'd0, 1'b0);
        cycle(ga, gb);
        set_a(1'b0, 1'b0, 4'd0, 64'd0, 1'b0);
        #1 rst_i = 1'b1;
        #1;
        model_reset();
        chk("rst_a_rvalid", {63'd0, a_rvalid_o}, 64'd0);
        chk("rst_a_rdata", a_rdata_o, 64'd0);
        cycle(ga, gb);
        #1 rst_i = 1'b0;
        set_a(1'b1, 1'b0, 4'd4, 64'd0, 1'b1);
        set_b(1'b1, 1'b0, 4'd5, 64'd0, 1'b1);
        cycle(ga, gb);
        chk("rst_idle_tie_a", {63'd0, ga}, 64'd1);
        set_a(1'b0, 1'b0, 4'd0, 64'd0, 1'b0);
        set_b(1'b0, 1'b0, 4'd0, 64'd0, 1'b0);
        cycle(ga, gb);

        // Randomized traffic; each requester holds its request until granted
        pa = 1'b0;
        pb = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pa) begin
                pa = ($urandom_range(0, 2) != 0);
                set_a(pa, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      {$urandom, $urandom}, pa && ($urandom_range(0, 3) == 0));
            end
            if (!pb) begin
                pb = ($urandom_range(0, 2) != 0);
                set_b(pb, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      {$urandom, $urandom}, pb && ($urandom_range(0, 3) == 0));
            end
            rst_i = ($urandom_range(0, 79) == 0);
            cycle(ga, gb);
            if (ga || rst_i) pa = 1'b0;
            if (gb || rst_i) pb = 1'b0;
        end
        rst_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
